// File: rtl/iexu_pipe_pkg.sv
// iexu_pipe_pkg: operation encodings, decoded controls and the decode helper
package iexu_pipe_pkg;

  typedef enum logic [3:0] {
    add_conf  = 4'd0,
    sub_conf  = 4'd1,
    and_conf  = 4'd2,
    or_conf   = 4'd3,
    xor_conf  = 4'd4,
    sll_conf  = 4'd5,
    srl_conf  = 4'd6,
    sra_conf  = 4'd7,
    slt_conf  = 4'd8,
    sltu_conf = 4'd9
  } iexu_conf;

  typedef enum logic [3:0] {
    alu_add, alu_sub, alu_and, alu_or, alu_xor,
    alu_sll, alu_srl, alu_sra, alu_slt, alu_sltu, alu_zero
  } alu_op_e;

  typedef struct packed {
    alu_op_e op;
    logic    err;
  } ctrl_t;

  // Unknown encodings still flow through the pipe, forcing a zero result.
  function automatic ctrl_t decode(input iexu_conf c);
    ctrl_t d;
    d = '{op: alu_zero, err: 1'b1};
    case (c)
      add_conf:  d = '{op: alu_add,  err: 1'b0};
      sub_conf:  d = '{op: alu_sub,  err: 1'b0};
      and_conf:  d = '{op: alu_and,  err: 1'b0};
      or_conf:   d = '{op: alu_or,   err: 1'b0};
      xor_conf:  d = '{op: alu_xor,  err: 1'b0};
      sll_conf:  d = '{op: alu_sll,  err: 1'b0};
      srl_conf:  d = '{op: alu_srl,  err: 1'b0};
      sra_conf:  d = '{op: alu_sra,  err: 1'b0};
      slt_conf:  d = '{op: alu_slt,  err: 1'b0};
      sltu_conf: d = '{op: alu_sltu, err: 1'b0};
      default:   d = '{op: alu_zero, err: 1'b1};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/iexu_alu_core.sv
// iexu_alu_core: combinational adder, logic unit, shifter, comparator and result mux
module iexu_alu_core
  import iexu_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e           op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   result
);
  localparam int SW = $clog2(XLEN);
  logic [SW-1:0] sh;
  logic          lt_s;
  logic          lt_u;
  assign sh   = b[SW-1:0];
  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;
  always_comb begin
    result = '0;
    case (op)
      alu_add:  result = a + b;
      alu_sub:  result = a - b;
      alu_and:  result = a & b;
      alu_or:   result = a | b;
      alu_xor:  result = a ^ b;
      alu_sll:  result = a << sh;
      alu_srl:  result = a >> sh;
      alu_sra:  result = $unsigned($signed(a) >>> sh);
      alu_slt:  result = {{(XLEN-1){1'b0}}, lt_s};
      alu_sltu: result = {{(XLEN-1){1'b0}}, lt_u};
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/iexu_pipe.sv
// iexu_pipe: two-stage integer execute pipe with valid/ready handshakes and flush
module iexu_pipe
  import iexu_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  iexu_conf         in_conf,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);
  logic             s1_v;
  ctrl_t            s1_ctrl;
  logic [XLEN-1:0]  s1_a;
  logic [XLEN-1:0]  s1_b;
  logic [TAG_W-1:0] s1_tag;
  logic [XLEN-1:0]  alu_res;
  logic             s2_adv;
  logic             s1_adv;
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_v || s2_adv;
  assign in_ready = s1_adv && !flush && !rst;
  always_ff @(posedge clk) begin
    if (rst || flush) s1_v <= 1'b0;
    else if (s1_adv) s1_v <= in_valid;
  end
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_ctrl <= decode(in_conf);
      s1_a    <= in_a;
      s1_b    <= in_b;
      s1_tag  <= in_tag;
    end
  end
  iexu_alu_core #(.XLEN(XLEN)) u_alu (
    .op     (s1_ctrl.op),
    .a      (s1_a),
    .b      (s1_b),
    .result (alu_res)
  );
  // S2 data only loads when a real op moves in, so outputs hold under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_v;
      if (s1_v) begin
        out_result <= alu_res;
        out_tag    <= s1_tag;
        out_err    <= s1_ctrl.err;
      end
    end
  end
endmodule

// File: tb/tb_iexu_pipe.sv
// tb_iexu_pipe: directed vectors with hand-computed results for iexu_pipe
module tb_iexu_pipe;
  import iexu_pipe_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  iexu_conf    in_conf = add_conf;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic        out_err;
  int checks = 0;
  int errors = 0;
  int acc = 0;
  iexu_conf    vc[4];
  logic [31:0] va[4], vb[4], ve[4];
  logic        verr[4];
  int          nv = 0;

  iexu_pipe #(.XLEN(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_conf(in_conf),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input iexu_conf c, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    in_valid = 1'b1;
    in_conf  = c;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
  endtask

  task automatic add_vec(input iexu_conf c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input logic err);
    vc[nv] = c; va[nv] = a; vb[nv] = b; ve[nv] = e; verr[nv] = err;
    nv++;
  endtask

  // One op per cycle; op i is visible after the edge that accepts op i+1.
  task automatic run_stream();
    out_ready = 1'b1;
    for (int i = 0; i <= nv; i++) begin
      if (i < nv) drive(vc[i], va[i], vb[i], 4'(i + 1));
      else in_valid = 1'b0;
      #1;
      if (i < nv) chk("stream_ready", in_ready, 1);
      tick();
      if (i >= 1) begin
        chk("stream_valid", out_valid, 1);
        chk("stream_result", out_result, ve[i-1]);
        chk("stream_tag", out_tag, i);
        chk("stream_err", out_err, verr[i-1]);
      end
    end
    tick();
    chk("stream_drain", out_valid, 0);
    nv = 0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_err", out_err, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);
    tick();

    add_vec(add_conf, 32'd5, 32'd7, 32'd12, 1'b0);
    add_vec(sub_conf, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0);
    add_vec(sra_conf, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    run_stream();

    add_vec(slt_conf, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    add_vec(sltu_conf, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    add_vec(sll_conf, 32'd1, 32'h21, 32'd2, 1'b0);
    run_stream();

    add_vec(and_conf, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0);
    add_vec(or_conf, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0);
    add_vec(xor_conf, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b0);
    add_vec(srl_conf, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0);
    run_stream();

    add_vec(iexu_conf'(4'hC), 32'd1, 32'd2, 32'd0, 1'b1);
    add_vec(add_conf, 32'd2, 32'd3, 32'd5, 1'b0);
    run_stream();

    // back-pressure: A and B fill both stages, C must wait
    out_ready = 1'b0;
    drive(add_conf, 32'd10, 32'd1, 4'd9);
    #1;
    if (in_valid && in_ready) acc++;
    tick();
    drive(sub_conf, 32'd10, 32'd1, 4'd10);
    #1;
    if (in_valid && in_ready) acc++;
    tick();
    drive(xor_conf, 32'hF0, 32'hFF, 4'd11);
    for (int i = 0; i < 3; i++) begin
      #1;
      if (in_valid && in_ready) acc++;
      chk("bp_ready_low", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_result", out_result, 32'd11);
      chk("bp_hold_tag", out_tag, 9);
      chk("bp_hold_err", out_err, 0);
      tick();
    end
    chk("bp_accepted", acc, 2);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_b_valid", out_valid, 1);
    chk("bp_b_result", out_result, 32'd9);
    chk("bp_b_tag", out_tag, 10);
    tick();
    chk("bp_c_valid", out_valid, 1);
    chk("bp_c_result", out_result, 32'h0F);
    chk("bp_c_tag", out_tag, 11);
    tick();
    chk("bp_drain", out_valid, 0);

    // flush with both stages full and a new op offered
    out_ready = 1'b0;
    drive(add_conf, 32'd1, 32'd1, 4'd12);
    #1;
    tick();
    drive(add_conf, 32'd2, 32'd2, 4'd13);
    #1;
    tick();
    chk("fl_full_valid", out_valid, 1);
    chk("fl_full_result", out_result, 32'd2);
    drive(add_conf, 32'd3, 32'd3, 4'd14);
    flush = 1'b1;
    #1;
    chk("fl_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_never", out_valid, 0);
    end

    // reset with two ops in flight
    drive(add_conf, 32'd4, 32'd4, 4'd1);
    #1;
    tick();
    drive(add_conf, 32'd5, 32'd5, 4'd2);
    #1;
    tick();
    chk("mr_inflight_valid", out_valid, 1);
    chk("mr_inflight_result", out_result, 32'd8);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mr_ready_in_rst", in_ready, 0);
    tick();
    chk("mr_valid", out_valid, 0);
    chk("mr_result", out_result, 0);
    chk("mr_tag", out_tag, 0);
    chk("mr_err", out_err, 0);
    rst = 1'b0;
    #1;
    chk("mr_ready", in_ready, 1);
    tick();
    chk("mr_s1_cleared", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
